// File: rtl/sbox_lane_engine.sv
// Iterative AES SubBytes/InvSubBytes engine: substitutes LANES bytes of a 128-bit state per beat.
// Define AES_SBOX_FWD_EN to build the forward tables; otherwise every block uses InvSubBytes.
module sbox_lane_engine #(
    parameter int LANES = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic         in_inv,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);
    localparam int BEATS = 16 / LANES;
    localparam int CNT_W = $clog2(BEATS) + 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    generate
        if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 && LANES != 16) begin : g_bad_lanes
            $error("sbox_lane_engine: LANES must be 1, 2, 4, 8 or 16");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t             state_q;
    logic [127:0]       data_q;
    logic [127:0]       data_d;
    logic [CNT_W-1:0]   cnt_q;
    logic               out_valid_q;
    logic               busy_q;
    logic               accept;
    int unsigned        lane_base;

`ifdef AES_SBOX_FWD_EN
    logic               inv_q;

    function automatic logic [7:0] fwd_sbox(input logic [7:0] a);
        logic [127:0] row;
        row = '0;
        case (a[7:4])
            4'h0: row = 128'h637c777bf26b6fc53001672bfed7ab76;
            4'h1: row = 128'hca82c97dfa5947f0add4a2af9ca472c0;
            4'h2: row = 128'hb7fd9326363ff7cc34a5e5f171d83115;
            4'h3: row = 128'h04c723c31896059a071280e2eb27b275;
            4'h4: row = 128'h09832c1a1b6e5aa0523bd6b329e32f84;
            4'h5: row = 128'h53d100ed20fcb15b6acbbe394a4c58cf;
            4'h6: row = 128'hd0efaafb434d338545f9027f503c9fa8;
            4'h7: row = 128'h51a3408f929d38f5bcb6da2110fff3d2;
            4'h8: row = 128'hcd0c13ec5f974417c4a77e3d645d1973;
            4'h9: row = 128'h60814fdc222a908846eeb814de5e0bdb;
            4'ha: row = 128'he0323a0a4906245cc2d3ac629195e479;
            4'hb: row = 128'he7c8376d8dd54ea96c56f4ea657aae08;
            4'hc: row = 128'hba78252e1ca6b4c6e8dd741f4bbd8b8a;
            4'hd: row = 128'h703eb5664803f60e613557b986c11d9e;
            4'he: row = 128'he1f8981169d98e949b1e87e9ce5528df;
            4'hf: row = 128'h8ca1890dbfe6426841992d0fb054bb16;
        endcase
        return row[127 - 8 * a[3:0] -: 8];
    endfunction
`else
    logic               unused_in_inv;
    assign unused_in_inv = in_inv;
`endif

    // Each row holds one table row, column 0 in the most significant byte.
    function automatic logic [7:0] inv_sbox(input logic [7:0] a);
        logic [127:0] row;
        row = '0;
        case (a[7:4])
            4'h0: row = 128'h52096ad53036a538bf40a39e81f3d7fb;
            4'h1: row = 128'h7ce339829b2fff87348e4344c4dee9cb;
            4'h2: row = 128'h547b9432a6c2233dee4c950b42fac34e;
            4'h3: row = 128'h082ea16628d924b2765ba2496d8bd125;
            4'h4: row = 128'h72f8f66486689816d4a45ccc5d65b692;
            4'h5: row = 128'h6c704850fdedb9da5e154657a78d9d84;
            4'h6: row = 128'h90d8ab008cbcd30af7e45805b8b34506;
            4'h7: row = 128'hd02c1e8fca3f0f02c1afbd0301138a6b;
            4'h8: row = 128'h3a9111414f67dcea97f2cfcef0b4e673;
            4'h9: row = 128'h96ac7422e7ad3585e2f937e81c75df6e;
            4'ha: row = 128'h47f11a711d29c5896fb7620eaa18be1b;
            4'hb: row = 128'hfc563e4bc6d279209adbc0fe78cd5af4;
            4'hc: row = 128'h1fdda8338807c731b11210592780ec5f;
            4'hd: row = 128'h60517fa919b54a0d2de57a9f93c99cef;
            4'he: row = 128'ha0e03b4dae2af5b0c8ebbb3c83539961;
            4'hf: row = 128'h172b047eba77d626e169146355210c7d;
        endcase
        return row[127 - 8 * a[3:0] -: 8];
    endfunction

    assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = out_valid_q;
    assign out_data  = data_q;
    assign busy      = busy_q;

    // The modulo keeps the lane window in range once the counter has run past the last beat.
    always_comb begin
        data_d    = data_q;
        lane_base = 32'(cnt_q % CNT_W'(BEATS)) * LANES;
        for (int unsigned l = 0; l < LANES; l++) begin
`ifdef AES_SBOX_FWD_EN
            data_d[8 * (lane_base + l) +: 8] = inv_q ? inv_sbox(data_q[8 * (lane_base + l) +: 8])
                                                     : fwd_sbox(data_q[8 * (lane_base + l) +: 8]);
`else
            data_d[8 * (lane_base + l) +: 8] = inv_sbox(data_q[8 * (lane_base + l) +: 8]);
`endif
        end
    end

    // accept is only possible in IDLE or in DONE while draining, so it is handled ahead of the state case.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            data_q      <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef AES_SBOX_FWD_EN
            inv_q       <= 1'b0;
`endif
        end else if (accept) begin
            state_q     <= BUSY;
            data_q      <= in_data;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b1;
`ifdef AES_SBOX_FWD_EN
            inv_q       <= in_inv;
`endif
        end else begin
            case (state_q)
                BUSY: begin
                    data_q <= data_d;
                    cnt_q  <= cnt_q + 1'b1;
                    if (cnt_q == LAST_BEAT) begin
                        state_q     <= DONE;
                        busy_q      <= 1'b0;
                        out_valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sbox_lane_engine.sv
// Directed bench for sbox_lane_engine: a LANES=4 and a LANES=1 instance against hand-computed FIPS-197 values.
module tb_sbox_lane_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;

    logic         v4, rdy4, inv4, ov4, ordy4, busy4;
    logic [127:0] d4, od4;

    logic         v1, rdy1, inv1, ov1, ordy1, busy1;
    logic [127:0] d1, od1;

    int tests = 0;
    int fails = 0;

    sbox_lane_engine #(.LANES(4)) u_dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (v4),
        .in_ready  (rdy4),
        .in_data   (d4),
        .in_inv    (inv4),
        .out_valid (ov4),
        .out_ready (ordy4),
        .out_data  (od4),
        .busy      (busy4)
    );

    sbox_lane_engine #(.LANES(1)) u_dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (v1),
        .in_ready  (rdy1),
        .in_data   (d1),
        .in_inv    (inv1),
        .out_valid (ov1),
        .out_ready (ordy1),
        .out_data  (od1),
        .busy      (busy1)
    );

    // Offers one block to the LANES=4 instance, flips in_inv after accept, waits for out_valid.
    task automatic run4(input logic [127:0] data, input logic inv,
                        output logic [127:0] res, output int lat);
        v4   = 1'b1;
        d4   = data;
        inv4 = inv;
        @(posedge clk); #1;
        v4   = 1'b0;
        inv4 = ~inv;
        d4   = '1;
        lat  = 0;
        while (!ov4 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        res = od4;
    endtask

    task automatic drain4;
        ordy4 = 1'b1;
        @(posedge clk); #1;
        ordy4 = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        v4 = 1'b0; d4 = '0; inv4 = 1'b0; ordy4 = 1'b0;
        v1 = 1'b0; d1 = '0; inv1 = 1'b0; ordy1 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        tests++; if (ov4 !== 1'b0)    begin fails++; $display("FAIL reset_out_valid4 got %b want 0", ov4); end
        tests++; if (busy4 !== 1'b0)  begin fails++; $display("FAIL reset_busy4 got %b want 0", busy4); end
        tests++; if (rdy4 !== 1'b1)   begin fails++; $display("FAIL reset_in_ready4 got %b want 1", rdy4); end
        tests++; if (od4 !== 128'h0)  begin fails++; $display("FAIL reset_out_data4 got %h want 0", od4); end
        tests++; if (ov1 !== 1'b0)    begin fails++; $display("FAIL reset_out_valid1 got %b want 0", ov1); end
        tests++; if (rdy1 !== 1'b1)   begin fails++; $display("FAIL reset_in_ready1 got %b want 1", rdy1); end
        tests++; if (od1 !== 128'h0)  begin fails++; $display("FAIL reset_out_data1 got %h want 0", od1); end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_inv_lanes4;
        int n;
        v4 = 1'b1; d4 = {16{8'h63}}; inv4 = 1'b1;
        @(posedge clk); #1;
        v4 = 1'b0;
        tests++; if (busy4 !== 1'b1) begin fails++; $display("FAIL l4_busy_after_accept got %b want 1", busy4); end
        tests++; if (rdy4 !== 1'b0)  begin fails++; $display("FAIL l4_ready_in_busy got %b want 0", rdy4); end
        n = 0;
        while (!ov4 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        tests++; if (n !== 4)             begin fails++; $display("FAIL l4_latency got %0d want 4", n); end
        tests++; if (od4 !== 128'h0)      begin fails++; $display("FAIL l4_inv63 got %h want 0", od4); end
        tests++; if (busy4 !== 1'b0)      begin fails++; $display("FAIL l4_busy_in_done got %b want 0", busy4); end
        drain4();
        tests++; if (ov4 !== 1'b0)        begin fails++; $display("FAIL l4_valid_after_drain got %b want 0", ov4); end
        tests++; if (rdy4 !== 1'b1)       begin fails++; $display("FAIL l4_idle_ready got %b want 1", rdy4); end
    endtask

    task automatic test_inv_lanes1;
        int n;
        int bc;
        v1 = 1'b1; inv1 = 1'b1;
        d1 = 128'hff00_5263_abcd_2030_4050_6070_8090_a0b0;
        @(posedge clk); #1;
        v1 = 1'b0;
        bc = busy1 ? 1 : 0;
        n  = 0;
        while (!ov1 && n < 40) begin
            @(posedge clk); #1;
            n++;
            if (busy1) bc++;
        end
        tests++; if (n !== 16)  begin fails++; $display("FAIL l1_latency got %0d want 16", n); end
        tests++; if (bc !== 16) begin fails++; $display("FAIL l1_busy_cycles got %0d want 16", bc); end
        tests++; if (od1 !== 128'h7d52_4800_0e80_5408_726c_90d0_3a96_47fc)
            begin fails++; $display("FAIL l1_block got %h want 7d5248000e805408726c90d03a9647fc", od1); end
        tests++; if (od1[127:120] !== 8'h7d) begin fails++; $display("FAIL l1_ff got %h want 7d", od1[127:120]); end
        tests++; if (od1[119:112] !== 8'h52) begin fails++; $display("FAIL l1_00 got %h want 52", od1[119:112]); end
        tests++; if (od1[111:104] !== 8'h48) begin fails++; $display("FAIL l1_52 got %h want 48", od1[111:104]); end
        ordy1 = 1'b1;
        @(posedge clk); #1;
        ordy1 = 1'b0;
        tests++; if (ov1 !== 1'b0) begin fails++; $display("FAIL l1_valid_after_drain got %b want 0", ov1); end
    endtask

    task automatic test_mode;
        logic [127:0] pat;
        logic [127:0] exp;
        logic [127:0] res;
        int n;
        pat = {{5{8'h00, 8'h53, 8'h52}}, 8'h00};
`ifdef AES_SBOX_FWD_EN
        exp = {{5{8'h63, 8'hed, 8'h00}}, 8'h63};
`else
        exp = {{5{8'h52, 8'h50, 8'h48}}, 8'h52};
`endif
        run4(pat, 1'b0, res, n);
        tests++; if (n !== 4)   begin fails++; $display("FAIL mode0_latency got %0d want 4", n); end
        tests++; if (res !== exp) begin fails++; $display("FAIL mode0_block got %h want %h", res, exp); end
        drain4();
        run4({16{8'h63}}, 1'b1, res, n);
        tests++; if (res !== 128'h0) begin fails++; $display("FAIL mode1_block got %h want 0", res); end
        drain4();
    endtask

    task automatic test_back_to_back;
        logic [127:0] res;
        int n;
        run4({16{8'h52}}, 1'b1, res, n);
        tests++; if (res !== {16{8'h48}}) begin fails++; $display("FAIL b2b_first got %h want 48..48", res); end
        v4 = 1'b1; d4 = {16{8'h00}}; inv4 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            tests++; if (od4 !== {16{8'h48}}) begin fails++; $display("FAIL hold_data[%0d] got %h want 48..48", i, od4); end
            tests++; if (rdy4 !== 1'b0)       begin fails++; $display("FAIL hold_ready[%0d] got %b want 0", i, rdy4); end
            tests++; if (ov4 !== 1'b1)        begin fails++; $display("FAIL hold_valid[%0d] got %b want 1", i, ov4); end
        end
        ordy4 = 1'b1;
        #1;
        tests++; if (rdy4 !== 1'b1) begin fails++; $display("FAIL b2b_ready got %b want 1", rdy4); end
        @(posedge clk); #1;
        ordy4 = 1'b0; v4 = 1'b0; inv4 = 1'b0;
        tests++; if (busy4 !== 1'b1) begin fails++; $display("FAIL b2b_busy got %b want 1", busy4); end
        tests++; if (ov4 !== 1'b0)   begin fails++; $display("FAIL b2b_valid_drop got %b want 0", ov4); end
        n = 0;
        while (!ov4 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        tests++; if (n !== 4)              begin fails++; $display("FAIL b2b_latency got %0d want 4", n); end
        tests++; if (od4 !== {16{8'h52}})  begin fails++; $display("FAIL b2b_second got %h want 52..52", od4); end
        drain4();
    endtask

    task automatic test_reset_mid_block;
        logic [127:0] res;
        int n;
        int seen;
        v4 = 1'b1; d4 = {16{8'h63}}; inv4 = 1'b1;
        @(posedge clk); #1;
        v4 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        tests++; if (busy4 !== 1'b0)  begin fails++; $display("FAIL midrst_busy got %b want 0", busy4); end
        tests++; if (od4 !== 128'h0)  begin fails++; $display("FAIL midrst_data got %h want 0", od4); end
        tests++; if (rdy4 !== 1'b1)   begin fails++; $display("FAIL midrst_ready got %b want 1", rdy4); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen = ov4 ? 1 : 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (ov4) seen++;
        end
        tests++; if (seen !== 0) begin fails++; $display("FAIL midrst_no_output got %0d valid cycles want 0", seen); end
        run4({16{8'hcd}}, 1'b1, res, n);
        tests++; if (n !== 4)             begin fails++; $display("FAIL postrst_latency got %0d want 4", n); end
        tests++; if (res !== {16{8'h80}}) begin fails++; $display("FAIL postrst_block got %h want 80..80", res); end
        drain4();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_inv_lanes4();
        test_inv_lanes1();
        test_mode();
        test_back_to_back();
        test_reset_mid_block();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
